// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing control for the 5-stage pipeline: load-use stalls, branch/jump flushes, memory freeze, watchdog.
// Control outputs are combinational (zero latency); state, fault and counters update on the following edge.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        ex_branch_taken,
  input  logic        id_jump,
  input  logic        mem_busy,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        ex_mem_hold,
  output logic        fault,
  output logic [1:0]  state,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FREEZE     = 2'd2,
    FAULT      = 2'd3
  } stateT;

  stateT      curState;
  logic [7:0] wdCnt;
  logic       luRaw;
  logic       lu;

  assign luRaw = ex_mem_read && (ex_rt != 5'd0) &&
                 ((id_use_rs && (id_rs == ex_rt)) || (id_use_rt && (id_rt == ex_rt)));
  // The bubble inserted by the previous stall already separates the pair.
  assign lu    = luRaw && (curState != LOAD_STALL);

  assign state = curState;
  assign fault = (curState == FAULT);

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_hold  = 1'b0;
    if (!reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (curState == FAULT) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      ex_mem_hold  = 1'b1;
    end else if (mem_busy) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      ex_mem_hold  = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (id_jump) begin
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
    end else if (lu) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      curState    <= RUN;
      wdCnt       <= 8'd0;
      stall_count <= 16'd0;
      flush_count <= 16'd0;
    end else begin
      wdCnt <= (mem_busy && (curState != FAULT)) ? wdCnt + 8'd1 : 8'd0;

      if (curState == FAULT)
        curState <= FAULT;
      else if (mem_busy && (wdCnt == 8'(MEM_TIMEOUT - 1)))
        curState <= FAULT;
      else if (mem_busy)
        curState <= FREEZE;
      else if ((curState == RUN) && lu && !ex_branch_taken)
        curState <= LOAD_STALL;
      else
        curState <= RUN;

      if ((curState != FAULT) && !pc_write && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
      if (if_id_flush && (flush_count != 16'hFFFF))
        flush_count <= flush_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: main instance (MEM_TIMEOUT=16) plus a watchdog instance (MEM_TIMEOUT=4).
module tb_pipeline_hazard_ctrl;

  logic clk;
  logic reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_use_rs, id_use_rt, ex_mem_read, ex_branch_taken, id_jump, mem_busy;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold, fault;
  logic [1:0] state;
  logic [15:0] stall_count, flush_count;

  logic wdReset, wdBusy;
  logic wdPcWrite, wdIfIdWrite, wdIfIdFlush, wdIdExBubble, wdExMemHold, wdFault;
  logic [1:0] wdState;
  logic [15:0] wdStallCount, wdFlushCount;

  int nAsserts = 0;
  int nFail = 0;

  // {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold}
  logic [4:0] ctl, wdCtl;
  assign ctl   = {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold};
  assign wdCtl = {wdPcWrite, wdIfIdWrite, wdIfIdFlush, wdIdExBubble, wdExMemHold};

  localparam logic [4:0] CTL_RESET  = 5'b00110;
  localparam logic [4:0] CTL_NORMAL = 5'b11000;
  localparam logic [4:0] CTL_LU     = 5'b00010;
  localparam logic [4:0] CTL_BRANCH = 5'b10110;
  localparam logic [4:0] CTL_JUMP   = 5'b10100;
  localparam logic [4:0] CTL_FREEZE = 5'b00001;
  localparam logic [4:0] CTL_FAULT  = 5'b00011;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .id_jump(id_jump), .mem_busy(mem_busy),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ex_mem_hold(ex_mem_hold), .fault(fault),
    .state(state), .stall_count(stall_count), .flush_count(flush_count)
  );

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) wdDut (
    .clk(clk), .reset(wdReset),
    .id_rs(5'd0), .id_rt(5'd0), .id_use_rs(1'b0), .id_use_rt(1'b0),
    .ex_mem_read(1'b0), .ex_rt(5'd0), .ex_branch_taken(1'b0),
    .id_jump(1'b0), .mem_busy(wdBusy),
    .pc_write(wdPcWrite), .if_id_write(wdIfIdWrite), .if_id_flush(wdIfIdFlush),
    .id_ex_bubble(wdIdExBubble), .ex_mem_hold(wdExMemHold), .fault(wdFault),
    .state(wdState), .stall_count(wdStallCount), .flush_count(wdFlushCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are then changed 1 time unit after posedge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; id_jump = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
  endtask

  task automatic setLoadUse();
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    wdReset = 1'b0;
    wdBusy = 1'b0;
    clearIn();

    // Reset values
    cyc(); #1;
    chk("reset_ctl", 32'(ctl), 32'(CTL_RESET));
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_fault", 32'(fault), 32'd0);
    chk("reset_stall", 32'(stall_count), 32'd0);
    chk("reset_flush", 32'(flush_count), 32'd0);
    reset = 1'b1;
    #1 chk("run_ctl", 32'(ctl), 32'(CTL_NORMAL));
    cyc(); #1;
    chk("post_reset_state", 32'(state), 32'd0);
    chk("post_reset_stall", 32'(stall_count), 32'd0);

    // Load-use: one stall, then masked in LOAD_STALL
    setLoadUse();
    #1 chk("lu_c0_ctl", 32'(ctl), 32'(CTL_LU));
    cyc(); #1;
    chk("lu_c1_ctl", 32'(ctl), 32'(CTL_NORMAL));
    chk("lu_c1_state", 32'(state), 32'd1);
    chk("lu_stall", 32'(stall_count), 32'd1);
    clearIn();
    cyc(); #1;
    chk("lu_back_run", 32'(state), 32'd0);
    // ex_rt == 0 never stalls
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
    #1 chk("lu_r0_ctl", 32'(ctl), 32'(CTL_NORMAL));
    cyc(); #1;
    chk("lu_r0_state", 32'(state), 32'd0);
    chk("lu_r0_stall", 32'(stall_count), 32'd1);
    clearIn();

    // Branch overrides load-use
    doReset();
    setLoadUse();
    ex_branch_taken = 1'b1;
    #1 chk("br_ctl", 32'(ctl), 32'(CTL_BRANCH));
    cyc(); clearIn(); #1;
    chk("br_state", 32'(state), 32'd0);
    chk("br_flush", 32'(flush_count), 32'd1);
    chk("br_stall", 32'(stall_count), 32'd0);

    // Jump
    doReset();
    id_jump = 1'b1;
    #1 chk("jmp_ctl", 32'(ctl), 32'(CTL_JUMP));
    cyc(); clearIn(); #1;
    chk("jmp_flush", 32'(flush_count), 32'd1);
    chk("jmp_state", 32'(state), 32'd0);

    // Freeze with a taken branch held in EX
    doReset();
    mem_busy = 1'b1;
    ex_branch_taken = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk($sformatf("frz_ctl_%0d", i), 32'(ctl), 32'(CTL_FREEZE));
      cyc(); #1;
      chk($sformatf("frz_state_%0d", i), 32'(state), 32'd2);
    end
    mem_busy = 1'b0;
    #1 chk("frz_exit_ctl", 32'(ctl), 32'(CTL_BRANCH));
    chk("frz_stall", 32'(stall_count), 32'd5);
    chk("frz_flush0", 32'(flush_count), 32'd0);
    cyc(); clearIn(); #1;
    chk("frz_exit_state", 32'(state), 32'd0);
    chk("frz_flush1", 32'(flush_count), 32'd1);

    // Watchdog, MEM_TIMEOUT=4: fault from busy index 4
    wdReset = 1'b1;
    cyc();
    wdBusy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc(); #1;
      chk($sformatf("wd_fault_%0d", i), 32'(wdFault), (i == 4) ? 32'd1 : 32'd0);
      chk($sformatf("wd_state_%0d", i), 32'(wdState), (i == 4) ? 32'd3 : 32'd2);
    end
    chk("wd_stall", 32'(wdStallCount), 32'd4);
    wdBusy = 1'b0;
    #1 chk("wd_fault_ctl", 32'(wdCtl), 32'(CTL_FAULT));
    cyc(); #1;
    chk("wd_sticky_fault", 32'(wdFault), 32'd1);
    chk("wd_sticky_state", 32'(wdState), 32'd3);
    chk("wd_sticky_ctl", 32'(wdCtl), 32'(CTL_FAULT));
    chk("wd_stall_hold", 32'(wdStallCount), 32'd4);
    wdReset = 1'b0;
    #1 chk("wd_rst_ctl", 32'(wdCtl), 32'(CTL_RESET));
    cyc();
    wdReset = 1'b1;
    #1;
    chk("wd_clr_fault", 32'(wdFault), 32'd0);
    chk("wd_clr_state", 32'(wdState), 32'd0);
    chk("wd_clr_stall", 32'(wdStallCount), 32'd0);
    chk("wd_clr_ctl", 32'(wdCtl), 32'(CTL_NORMAL));

    // Saturation: 4368 bursts of 15 + one of 14 = 65534 stall cycles
    doReset();
    for (int b = 0; b < 4368; b++) begin
      mem_busy = 1'b1;
      repeat (15) cyc();
      mem_busy = 1'b0;
      cyc();
    end
    mem_busy = 1'b1;
    repeat (14) cyc();
    mem_busy = 1'b0;
    cyc(); #1;
    chk("sat_fffe", 32'(stall_count), 32'h0000FFFE);
    chk("sat_state", 32'(state), 32'd0);
    mem_busy = 1'b1;
    repeat (3) cyc();
    mem_busy = 1'b0;
    cyc(); #1;
    chk("sat_ffff", 32'(stall_count), 32'h0000FFFF);
    chk("sat_flush", 32'(flush_count), 32'd0);
    chk("sat_no_fault", 32'(fault), 32'd0);

    // Reset clears everything
    reset = 1'b0;
    #1 chk("final_rst_ctl", 32'(ctl), 32'(CTL_RESET));
    cyc(); #1;
    chk("final_stall", 32'(stall_count), 32'd0);
    chk("final_flush", 32'(flush_count), 32'd0);
    chk("final_state", 32'(state), 32'd0);
    chk("final_fault", 32'(fault), 32'd0);
    chk("final_ctl", 32'(ctl), 32'(CTL_RESET));

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage MIPS pipeline. Owns the write-enable, flush and bubble controls of the IF/ID pipeline register, the PC and the ID/EX register. Resolves load-use stalls, taken-branch/jump redirects and multi-cycle data-memory waits. Adds a memory-wait watchdog and saturating performance counters. Sits beside the IF/ID register and drives its control pins.

## Interface
- MEM_TIMEOUT, 16: consecutive `mem_busy` cycles before FAULT (range 2..255).
- clk  input  1  pipeline clock; all state updates on posedge.
- reset  input  1  synchronous, active-low; sampled on posedge clk.
- id_rs, id_rt  input  5 each  source register fields of the instruction in ID.
- id_use_rs, id_use_rt  input  1 each  ID instruction reads rs / rt.
- ex_mem_read  input  1  instruction in EX is a load.
- ex_rt  input  5  load destination register in EX.
- ex_branch_taken  input  1  branch in EX resolved taken.
- id_jump  input  1  jump decoded in ID.
- mem_busy  input  1  data memory not ready; the pipeline must freeze.
- pc_write  output  1  PC update enable.
- if_id_write  output  1  IF/ID load enable.
- if_id_flush  output  1  IF/ID clear to NOP; takes priority over if_id_write.
- id_ex_bubble  output  1  load NOP into ID/EX.
- ex_mem_hold  output  1  hold EX/MEM and MEM/WB.
- fault  output  1  sticky watchdog fault.
- state  output  2  FSM state: RUN=0, LOAD_STALL=1, FREEZE=2, FAULT=3.
- stall_count  output  16  saturating count of stall cycles.
- flush_count  output  16  saturating count of flush cycles.

## Operation
- Load-use hazard (lu):
  - lu = ex_mem_read & (ex_rt != 0) & ((id_use_rs & id_rs == ex_rt) | (id_use_rt & id_rt == ex_rt)).
  - lu is masked in LOAD_STALL.
- Control outputs are combinational from the current state and inputs. Priority, highest first:
  1. reset==0: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, ex_mem_hold=0.
  2. state FAULT: pc_write=0, if_id_write=0, id_ex_bubble=1, ex_mem_hold=1, flush=0.
  3. mem_busy: pc_write=0, if_id_write=0, id_ex_bubble=0, ex_mem_hold=1, flush=0. The whole pipeline freezes.
  4. ex_branch_taken: pc_write=1, if_id_flush=1, id_ex_bubble=1. Two wrong-path instructions are killed.
  5. id_jump: pc_write=1, if_id_flush=1, id_ex_bubble=0.
  6. lu: pc_write=0, if_id_write=0, id_ex_bubble=1.
  7. Otherwise: pc_write=1, if_id_write=1, all others 0.
- A branch outranks load-use and jump: the stalled or jumping instruction is on the wrong path.
- FSM transitions at posedge, evaluated top-down:
  - reset==0: go to RUN.
  - FAULT: stay in FAULT; only reset exits.
  - mem_busy & wd_cnt == MEM_TIMEOUT-1: go to FAULT.
  - mem_busy: go to FREEZE.
  - RUN & lu & no branch: go to LOAD_STALL.
  - Otherwise: go to RUN.
  - A LOAD_STALL that gets mem_busy goes to FREEZE. After FREEZE it returns to RUN with the lu mask cleared. The bubble is already in ID/EX, so lu deasserts naturally.
- Watchdog wd_cnt (8 bit):
  - Increments every cycle mem_busy=1.
  - Clears when mem_busy=0, on reset, and in FAULT.
- fault = (state == FAULT), so it is registered and sticky.
- Counters:
  - Reset to 0 and saturate at 16'hFFFF (no wrap).
  - stall_count +1 on any cycle with reset=1, not FAULT, and pc_write=0 (freeze or lu).
  - flush_count +1 on any cycle with reset=1 and if_id_flush=1.

## Timing
- Output reset values, while reset is low: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, ex_mem_hold=0, fault=0, state=0, counters=0.
- Registered outputs are 0 on the first cycle after reset rises.
- Control outputs have zero-cycle latency from inputs. `state`, `fault` and the counters update one edge after the causing cycle.
- Load-use costs exactly one stall cycle. In the following cycle (LOAD_STALL) lu is ignored even if inputs hold.
- Freeze lasts exactly as long as mem_busy is high. The first cycle with mem_busy=0 applies the normal priority, including any branch still held in EX.
- The watchdog trips after MEM_TIMEOUT consecutive busy cycles: fault=1 in busy cycle index MEM_TIMEOUT, where the first busy cycle is index 0.
- Reset low mid-freeze or in FAULT returns to RUN at the next edge and clears wd_cnt and the counters.

## Test plan
- Load-use:
  - Stimulus: ex_mem_read=1, ex_rt=5, id_rs=5, id_use_rs=1 for 2 cycles.
  - Required: cycle 0 gives pc_write=0, if_id_write=0, id_ex_bubble=1. Cycle 1 gives normal outputs and state=1. stall_count=1.
  - Repeat with ex_rt=0: no stall.
- Branch overrides load-use:
  - Stimulus: lu true and ex_branch_taken=1 in the same cycle.
  - Required: pc_write=1, if_id_flush=1, id_ex_bubble=1. state stays RUN. flush_count=1, stall_count=0.
- Jump:
  - Stimulus: id_jump=1 for one cycle.
  - Required: if_id_flush=1, pc_write=1, id_ex_bubble=0. flush_count=1.
- Freeze:
  - Stimulus: mem_busy=1 for 5 cycles with ex_branch_taken=1 held throughout.
  - Required: for 5 cycles ex_mem_hold=1, pc_write=0, no flush. Cycle 6 applies the flush. stall_count=5, state=2 during the freeze.
- Watchdog:
  - Stimulus: MEM_TIMEOUT=4, mem_busy held high.
  - Required: fault=1 and state=3 from the 5th busy cycle. Outputs stay frozen after mem_busy drops. A reset pulse clears fault and state.
- Saturation and reset:
  - Stimulus: force stall_count near 16'hFFFE and add 3 stall cycles.
  - Required: stall_count holds at 16'hFFFF.
  - Then reset=0 for 1 cycle: all counters 0 and reset output values as listed in Timing.
